// File: rtl/regwr_pkg.sv
// Shared types and constants for the register-bank writeback arbiter.
package regwr_pkg;

  localparam int REGWR_DATA_W = 32;
  localparam int REGWR_ADDR_W = 5;
  localparam int ZERO_REG     = 0;

  // Two bits are enough: an entry is granted no later than its second cycle held.
  localparam int AGE_W = 2;
  typedef logic [AGE_W-1:0] age_t;

  typedef struct packed {
    logic                    valid;
    logic [REGWR_ADDR_W-1:0] dr;
    logic [REGWR_DATA_W-1:0] data;
    age_t                    age;
  } regwr_entry_t;

  function automatic age_t age_inc(input age_t a);
    return (a == '1) ? a : a + age_t'(1);
  endfunction

endpackage

// File: rtl/regwr_slot.sv
// One-entry holding register for a writeback requester; age counts cycles held.
module regwr_slot
  import regwr_pkg::*;
#(
  parameter int DATA_W = REGWR_DATA_W,
  parameter int ADDR_W = REGWR_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_dr,
  input  logic [DATA_W-1:0] push_data,
  output logic              valid,
  output logic [ADDR_W-1:0] dr,
  output logic [DATA_W-1:0] data,
  output age_t              age
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      dr    <= '0;
      data  <= '0;
      age   <= '0;
    end else if (push) begin
      // A push during a pop replaces the entry; the newcomer starts youngest.
      valid <= 1'b1;
      dr    <= push_dr;
      data  <= push_data;
      age   <= '0;
    end else if (pop) begin
      valid <= 1'b0;
    end else if (valid) begin
      age <= age_inc(age);
    end
  end

endmodule

// File: rtl/regwr_arbiter.sv
// Arbitrates ALU (A) and load (B) writebacks onto one registered register-bank
// write port, oldest first (B on ties). Optional macro: REGWR_ZERO_DROP_EN.
module regwr_arbiter
  import regwr_pkg::*;
#(
  parameter int DATA_W = REGWR_DATA_W,
  parameter int ADDR_W = REGWR_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_dr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_dr,
  input  logic [DATA_W-1:0] b_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_dr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] q_sr1,
  input  logic [ADDR_W-1:0] q_sr2,
  output logic              q_hit1,
  output logic              q_hit2
);

  logic              av, bv;
  logic [ADDR_W-1:0] adr, bdr;
  logic [DATA_W-1:0] adata, bdata;
  age_t              aage, bage;
  logic              grant_a, grant_b;
  logic              push_a, push_b;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (av && bv) begin
      if (aage > bage) grant_a = 1'b1;
      else             grant_b = 1'b1;
    end else begin
      grant_a = av;
      grant_b = bv;
    end
  end

  assign a_ready = reset && (!av || grant_a);
  assign b_ready = reset && (!bv || grant_b);

`ifdef REGWR_ZERO_DROP_EN
  // Writes to the zero register are consumed here and never reach the bank.
  assign push_a = a_valid && a_ready && (a_dr != ADDR_W'(ZERO_REG));
  assign push_b = b_valid && b_ready && (b_dr != ADDR_W'(ZERO_REG));
`else
  assign push_a = a_valid && a_ready;
  assign push_b = b_valid && b_ready;
`endif

  regwr_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_a (
    .clk       (clk),
    .reset     (reset),
    .push      (push_a),
    .pop       (grant_a),
    .push_dr   (a_dr),
    .push_data (a_data),
    .valid     (av),
    .dr        (adr),
    .data      (adata),
    .age       (aage)
  );

  regwr_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_b (
    .clk       (clk),
    .reset     (reset),
    .push      (push_b),
    .pop       (grant_b),
    .push_dr   (b_dr),
    .push_data (b_data),
    .valid     (bv),
    .dr        (bdr),
    .data      (bdata),
    .age       (bage)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en   <= 1'b0;
      wr_dr   <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= grant_a || grant_b;
      if (grant_b) begin
        wr_dr   <= bdr;
        wr_data <= bdata;
      end else if (grant_a) begin
        wr_dr   <= adr;
        wr_data <= adata;
      end
    end
  end

  // Hazard lookup covers both held entries and the write being presented now.
  always_comb begin
    q_hit1 = 1'b0;
    q_hit2 = 1'b0;
    if (q_sr1 != ADDR_W'(ZERO_REG))
      q_hit1 = (av && adr == q_sr1) || (bv && bdr == q_sr1) || (wr_en && wr_dr == q_sr1);
    if (q_sr2 != ADDR_W'(ZERO_REG))
      q_hit2 = (av && adr == q_sr2) || (bv && bdr == q_sr2) || (wr_en && wr_dr == q_sr2);
  end

endmodule

// File: tb/tb_regwr_arbiter.sv
// Directed self-checking bench for regwr_arbiter (honours REGWR_ZERO_DROP_EN).
module tb_regwr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_dr, b_dr, wr_dr, q_sr1, q_sr2;
  logic [31:0] a_data, b_data, wr_data;
  logic        wr_en, q_hit1, q_hit2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regwr_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_dr(a_dr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_dr(b_dr), .b_data(b_data),
    .wr_en(wr_en), .wr_dr(wr_dr), .wr_data(wr_data),
    .q_sr1(q_sr1), .q_sr2(q_sr2), .q_hit1(q_hit1), .q_hit2(q_hit2)
  );

  typedef struct {
    int av, adr, ad, bv, bdr, bd, s1, s2;
    int ra, rb, we, wdr, wd, h1, h2;
  } vec_t;

  vec_t vt[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(int av, int adr, int ad, int bv, int bdr, int bd, int s1, int s2,
                               int ra, int rb, int we, int wdr, int wd, int h1, int h2);
    vec_t v;
    v.av = av; v.adr = adr; v.ad = ad; v.bv = bv; v.bdr = bdr; v.bd = bd;
    v.s1 = s1; v.s2 = s2; v.ra = ra; v.rb = rb; v.we = we; v.wdr = wdr;
    v.wd = wd; v.h1 = h1; v.h2 = h2;
    return v;
  endfunction

  task automatic idle_inputs();
    a_valid = 1'b0; a_dr = '0; a_data = '0;
    b_valid = 1'b0; b_dr = '0; b_data = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_port(input string tag, input int we, input int wdr, input int wd);
    check({tag, " wr_en"}, 32'(wr_en), we);
    check({tag, " wr_dr"}, 32'(wr_dr), wdr);
    check({tag, " wr_data"}, wr_data, wd);
  endtask

  initial begin
    logic [31:0] expq[$];
    int a_idx, b_idx;
    logic acc_a, acc_b;

    reset = 1'b0;
    idle_inputs();
    q_sr1 = '0; q_sr2 = '0;
    next_cycle();
    next_cycle();

    // Reset state.
    q_sr1 = 5'd3;
    #1;
    check("rst a_ready", 32'(a_ready), 0);
    check("rst b_ready", 32'(b_ready), 0);
    check_port("rst", 0, 0, 0);
    check("rst q_hit1", 32'(q_hit1), 0);

    // Table: each row is one cycle; row 0 is the first cycle after reset release.
    //            av adr ad     bv bdr bd     s1 s2  ra rb we wdr wd    h1 h2
    vt[0]  = mkv(1, 3, 'h11,  0, 0, 0,     3, 0,  1, 1, 0, 0, 0,    0, 0);
    vt[1]  = mkv(0, 0, 0,     0, 0, 0,     3, 0,  1, 1, 0, 0, 0,    1, 0);
    vt[2]  = mkv(0, 0, 0,     0, 0, 0,     3, 0,  1, 1, 1, 3, 'h11, 1, 0);
    vt[3]  = mkv(0, 0, 0,     0, 0, 0,     3, 0,  1, 1, 0, 3, 'h11, 0, 0);
    vt[4]  = mkv(1, 4, 'h44,  1, 5, 'h55,  4, 5,  1, 1, 0, 3, 'h11, 0, 0);
    vt[5]  = mkv(0, 0, 0,     0, 0, 0,     4, 5,  0, 1, 0, 3, 'h11, 1, 1);
    vt[6]  = mkv(0, 0, 0,     0, 0, 0,     4, 5,  1, 1, 1, 5, 'h55, 1, 1);
    vt[7]  = mkv(0, 0, 0,     0, 0, 0,     4, 5,  1, 1, 1, 4, 'h44, 1, 0);
    vt[8]  = mkv(0, 0, 0,     0, 0, 0,     4, 5,  1, 1, 0, 4, 'h44, 0, 0);
    vt[9]  = mkv(0, 0, 0,     1, 7, 'hAA,  7, 0,  1, 1, 0, 4, 'h44, 0, 0);
    vt[10] = mkv(1, 7, 'hBB,  0, 0, 0,     7, 0,  1, 1, 0, 4, 'h44, 1, 0);
    vt[11] = mkv(0, 0, 0,     0, 0, 0,     7, 0,  1, 1, 1, 7, 'hAA, 1, 0);
    vt[12] = mkv(0, 0, 0,     0, 0, 0,     7, 0,  1, 1, 1, 7, 'hBB, 1, 0);
    vt[13] = mkv(0, 0, 0,     0, 0, 0,     7, 0,  1, 1, 0, 7, 'hBB, 0, 0);

    reset = 1'b1;
    for (int i = 0; i < 14; i++) begin
      a_valid = vt[i].av[0]; a_dr = 5'(vt[i].adr); a_data = 32'(vt[i].ad);
      b_valid = vt[i].bv[0]; b_dr = 5'(vt[i].bdr); b_data = 32'(vt[i].bd);
      q_sr1 = 5'(vt[i].s1); q_sr2 = 5'(vt[i].s2);
      #1;
      check($sformatf("v%0d a_ready", i), 32'(a_ready), vt[i].ra);
      check($sformatf("v%0d b_ready", i), 32'(b_ready), vt[i].rb);
      check_port($sformatf("v%0d", i), vt[i].we, vt[i].wdr, vt[i].wd);
      check($sformatf("v%0d q_hit1", i), 32'(q_hit1), vt[i].h1);
      check($sformatf("v%0d q_hit2", i), 32'(q_hit2), vt[i].h2);
      next_cycle();
    end
    idle_inputs();

    // Continuous streams: grants alternate B, A, B, A ... from the third cycle.
    for (int k = 0; k < 12; k++) begin
      expq.push_back(32'hB000_0000 + 32'(k));
      expq.push_back(32'hA000_0000 + 32'(k));
    end
    a_idx = 0; b_idx = 0;
    q_sr1 = '0; q_sr2 = '0;
    for (int s = 1; s <= 20; s++) begin
      a_valid = 1'b1; a_dr = 5'd10; a_data = 32'hA000_0000 + 32'(a_idx);
      b_valid = 1'b1; b_dr = 5'd20; b_data = 32'hB000_0000 + 32'(b_idx);
      #1;
      check($sformatf("s%0d a_ready", s), 32'(a_ready), (s == 1) ? 1 : s % 2);
      check($sformatf("s%0d b_ready", s), 32'(b_ready), (s == 1) ? 1 : 1 - s % 2);
      check($sformatf("s%0d wr_en", s), 32'(wr_en), (s >= 3) ? 1 : 0);
      if (s >= 3) begin
        check($sformatf("s%0d wr_data", s), wr_data, expq[s-3]);
        check($sformatf("s%0d wr_dr", s), 32'(wr_dr), (s % 2 == 1) ? 20 : 10);
      end
      acc_a = a_ready; acc_b = b_ready;
      next_cycle();
      if (acc_a) a_idx++;
      if (acc_b) b_idx++;
    end
    idle_inputs();
    repeat (4) next_cycle();
    check("drain wr_en", 32'(wr_en), 0);

    // Reset mid-operation: B written, A still held when reset falls.
    q_sr1 = 5'd9;
    a_valid = 1'b1; a_dr = 5'd9; a_data = 32'h99;
    b_valid = 1'b1; b_dr = 5'd9; b_data = 32'h9A;
    next_cycle();
    idle_inputs();
    next_cycle();
    check_port("mid pre", 1, 9, 32'h9A);
    reset = 1'b0;
    #1;
    check_port("mid rst", 0, 0, 0);
    check("mid rst a_ready", 32'(a_ready), 0);
    check("mid rst b_ready", 32'(b_ready), 0);
    check("mid rst q_hit1", 32'(q_hit1), 0);
    next_cycle();
    reset = 1'b1;
    #1;
    check("mid rel a_ready", 32'(a_ready), 1);
    check("mid rel b_ready", 32'(b_ready), 1);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("mid post%0d wr_en", c), 32'(wr_en), 0);
      check($sformatf("mid post%0d q_hit1", c), 32'(q_hit1), 0);
      next_cycle();
    end

    // Writes to register zero.
    q_sr1 = '0; q_sr2 = '0;
    a_valid = 1'b1; a_dr = '0; a_data = 32'h77;
    #1;
    check("zero c1 a_ready", 32'(a_ready), 1);
    next_cycle();
    idle_inputs();
    #1;
    check("zero c2 a_ready", 32'(a_ready), 1);
    check("zero c2 wr_en", 32'(wr_en), 0);
    check("zero c2 q_hit1", 32'(q_hit1), 0);
    next_cycle();
`ifdef REGWR_ZERO_DROP_EN
    check("zero c3 wr_en", 32'(wr_en), 0);
`else
    check_port("zero c3", 1, 0, 32'h77);
`endif
    check("zero c3 q_hit1", 32'(q_hit1), 0);
    next_cycle();
    check("zero c4 wr_en", 32'(wr_en), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regwr_arbiter.md
REGWR_ARBITER -- requirements
Module: regwr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: write data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5: register index width.
REQ-003 The block SHALL have port clk, input, 1, the single clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports a_valid/a_ready, in/out, 1 each: ALU writeback handshake.
REQ-006 The block SHALL have ports a_dr/a_data, in, ADDR_W/DATA_W: ALU destination and value.
REQ-007 The block SHALL have ports b_valid/b_ready, in/out, 1 each: load writeback handshake.
REQ-008 The block SHALL have ports b_dr/b_data, in, ADDR_W/DATA_W: load destination and value.
REQ-009 The block SHALL have ports wr_en/wr_dr/wr_data, out, 1/ADDR_W/DATA_W: register-bank write port, registered.
REQ-010 The block SHALL have ports q_sr1/q_sr2, in, ADDR_W: hazard query indices.
REQ-011 The block SHALL have ports q_hit1/q_hit2, out, 1: pending write exists for the queried index.

Function
REQ-012 The block SHALL hold one entry (valid, dr, data, age) per requester.
REQ-013 The block SHALL accept a transfer on a requester when valid and ready are both high at a rising edge.
REQ-014 x_ready SHALL equal (entry empty) or (entry granted this cycle); simultaneous pop and push are allowed.
REQ-015 Each cycle at most one full entry SHALL be granted: the older entry; on an age tie (both loaded at the same edge), B.
REQ-016 A grant SHALL load wr_en=1, wr_dr, wr_data at the same edge that frees the entry; data accepted at edge N appears on the write port during cycle N+2 at the earliest.
REQ-017 wr_en SHALL be 0 in any cycle following an edge with no grant; wr_dr/wr_data SHALL hold their last values.
REQ-018 When both entries hold the same dr, the older SHALL be written first, so the younger value is final.
REQ-019 The ungranted entry SHALL remain full and stable; a full entry SHALL be granted within 2 cycles of becoming the older entry.
REQ-020 q_hitN SHALL be combinational and high when q_srN is non-zero and matches a full entry or the output stage with wr_en=1.
REQ-021 q_hitN SHALL be 0 for q_srN=0.

Reset
REQ-022 While reset is low: entries empty, a_ready=b_ready=0, wr_en=0, wr_dr=0, wr_data=0, age state cleared.
REQ-023 Assertion mid-operation SHALL discard all held entries without issuing any write.
REQ-024 In the first cycle after reset deasserts, a_ready=b_ready=1.

Configuration
REQ-025 With macro REGWR_ZERO_DROP_EN defined, a transfer with dr=0 SHALL be accepted (ready per REQ-014), never occupy an entry, and never produce wr_en.
REQ-026 Without REGWR_ZERO_DROP_EN, dr=0 transfers SHALL be arbitrated and written like any other.

Structure
REQ-027 Package regwr_pkg SHALL hold DATA_W/ADDR_W defaults, the ZERO_REG constant, and the entry struct typedef (valid, dr, data, age).
REQ-028 Sub-module regwr_slot (one-entry holding register with push/pop/age) SHALL be instantiated once per requester.

Verification
REQ-029 Reset then A only: a_dr=3, a_data=0x11 accepted at edge 1 -> wr_en=1, wr_dr=3, wr_data=0x11 in cycle 3; q_hit1 high for q_sr1=3 in cycles 2-3.
REQ-030 A and B valid at the same edge, dr 4 and 5 -> B written first, A next cycle; a_ready low for one cycle.
REQ-031 B(dr=7, 0xAA) accepted, A(dr=7, 0xBB) accepted one edge later -> writes in order 0xAA then 0xBB.
REQ-032 Continuous A and B streams for 20 cycles -> wr_en high every cycle after fill, grants alternate, no entry waits more than 2 cycles.
REQ-033 Both entries full, reset pulsed low -> wr_en=0 immediately, no write of held data after release, readies high next cycle.
REQ-034 a_dr=0 with REGWR_ZERO_DROP_EN -> no wr_en, a_ready stays high; without the macro -> wr_en=1, wr_dr=0.
